// File: rtl/cbfp_pkg.sv
// Shared types and helpers for the CBFP normalizer slice.
package cbfp_pkg;

    localparam int unsigned LANES      = 16;
    localparam int unsigned DATA_WIDTH = 23;
    localparam int unsigned MAG_WIDTH  = 5;
    localparam int unsigned OUT_WIDTH  = 11;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic        [MAG_WIDTH-1:0]  mag_t;
    typedef logic signed [OUT_WIDTH-1:0]  out_t;

    typedef sample_t lane_vec_t [0:LANES-1];
    typedef mag_t    mag_vec_t  [0:LANES-1];
    typedef out_t    out_vec_t  [0:LANES-1];

    typedef enum logic {
        RD_IDLE,
        RD_OUT
    } rd_state_t;

    function automatic mag_t min2(input mag_t a, input mag_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic mag_t clamp_mag(input mag_t m);
        return (m >= mag_t'(DATA_WIDTH)) ? mag_t'(DATA_WIDTH - 1) : m;
    endfunction

endpackage

// File: rtl/cbfp_normalize_if.sv
// Sample/exponent bus between the magnitude detector, the normalizer and its consumer.
interface cbfp_normalize_if
    import cbfp_pkg::*;
();
    logic      valid_in;
    lane_vec_t din;
    mag_vec_t  mag_in;
    logic      valid_out;
    logic      sop_out;
    out_vec_t  dout;
    mag_t      exp_out;

    modport master (
        output valid_in, din, mag_in,
        input  valid_out, sop_out, dout, exp_out
    );

    modport slave (
        input  valid_in, din, mag_in,
        output valid_out, sop_out, dout, exp_out
    );
endinterface

// File: rtl/cbfp_min16.sv
// Combinational 16-input minimum as a balanced 4-level compare tree.
module cbfp_min16
    import cbfp_pkg::*;
(
    input  mag_vec_t mag,
    output mag_t     min_out
);
    mag_t l1 [0:7];
    mag_t l2 [0:3];
    mag_t l3 [0:1];

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) l1[i] = min2(mag[2*i], mag[2*i+1]);
        for (int unsigned i = 0; i < 4; i++) l2[i] = min2(l1[2*i], l1[2*i+1]);
        for (int unsigned i = 0; i < 2; i++) l3[i] = min2(l2[2*i], l2[2*i+1]);
        min_out = min2(l3[0], l3[1]);
    end
endmodule

// File: rtl/cbfp_normalize.sv
// CBFP block normalizer: ping-pong block buffer, block-min exponent, shift and truncate.
// Optional CBFP_ROUND_EN adds round-half-up with positive saturation and one extra stage.
module cbfp_normalize
    import cbfp_pkg::*;
#(
    parameter int unsigned BLK_BEATS = 4
) (
    input logic             clk,
    input logic             rstn,
    cbfp_normalize_if.slave bus
);
    localparam int unsigned CW = $clog2(BLK_BEATS);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(BLK_BEATS - 1);

    lane_vec_t mem [0:1][0:BLK_BEATS-1];
    mag_t      bexp [0:1];
    logic [1:0] full;
    logic      wr_bank, rd_bank;
    cnt_t      wr_cnt, rd_cnt;
    mag_t      run_min, lane_min, cur_min;
    mag_vec_t  mag_c;
    rd_state_t state, state_nxt;
    logic      emit, rd_done;
    lane_vec_t rd_data;
    mag_t      rd_exp;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) mag_c[i] = clamp_mag(bus.mag_in[i]);
    end

    cbfp_min16 u_min16 (
        .mag     (mag_c),
        .min_out (lane_min)
    );

    always_comb cur_min = (wr_cnt == '0) ? lane_min : min2(run_min, lane_min);

    always_ff @(posedge clk) begin
        if (bus.valid_in) mem[wr_bank][wr_cnt] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            run_min <= '0;
            full    <= '0;
            bexp[0] <= '0;
            bexp[1] <= '0;
        end else begin
            if (rd_done) full[rd_bank] <= 1'b0;
            if (bus.valid_in) begin
                wr_cnt  <= wr_cnt + cnt_t'(1);
                run_min <= cur_min;
                if (wr_cnt == LAST) begin
                    bexp[wr_bank] <= cur_min;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
        end
    end

    // Beat 0 is emitted straight from IDLE so the first output lands one cycle
    // after the closing write; rd_cnt therefore counts beats already issued.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        rd_done   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    emit      = 1'b1;
                    state_nxt = RD_OUT;
                end
            end
            RD_OUT: begin
                emit = 1'b1;
                if (rd_cnt == LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = full[~rd_bank] ? RD_OUT : RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (emit) rd_cnt <= rd_cnt + cnt_t'(1);
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    always_comb begin
        rd_data = mem[rd_bank][rd_cnt];
        rd_exp  = bexp[rd_bank];
    end

`ifdef CBFP_ROUND_EN
    localparam logic [DATA_WIDTH-1:0] HALF =
        {{OUT_WIDTH{1'b0}}, 1'b1, {(DATA_WIDTH-OUT_WIDTH-1){1'b0}}};
    localparam out_t OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    sample_t p_sh [0:LANES-1];
    logic    p_valid, p_sop;
    mag_t    p_exp;
    logic [DATA_WIDTH-1:0] rsum [0:LANES-1];
    out_t    rnd  [0:LANES-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p_valid <= 1'b0;
            p_sop   <= 1'b0;
            p_exp   <= '0;
        end else begin
            p_valid <= emit;
            p_sop   <= emit && (rd_cnt == '0);
            if (emit) begin
                p_exp <= rd_exp;
                for (int unsigned i = 0; i < LANES; i++) p_sh[i] <= rd_data[i] <<< rd_exp;
            end
        end
    end

    // Only a non-negative sample can carry into the sign bit.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            rsum[i] = p_sh[i] + HALF;
            rnd[i]  = (!p_sh[i][DATA_WIDTH-1] && rsum[i][DATA_WIDTH-1]) ? OUT_MAX
                    : out_t'(rsum[i] >> (DATA_WIDTH - OUT_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.valid_out <= 1'b0;
            bus.sop_out   <= 1'b0;
            bus.exp_out   <= '0;
            for (int unsigned i = 0; i < LANES; i++) bus.dout[i] <= '0;
        end else begin
            bus.valid_out <= p_valid;
            bus.sop_out   <= p_sop;
            if (p_valid) begin
                bus.exp_out <= p_exp;
                for (int unsigned i = 0; i < LANES; i++) bus.dout[i] <= rnd[i];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.valid_out <= 1'b0;
            bus.sop_out   <= 1'b0;
            bus.exp_out   <= '0;
            for (int unsigned i = 0; i < LANES; i++) bus.dout[i] <= '0;
        end else begin
            bus.valid_out <= emit;
            bus.sop_out   <= emit && (rd_cnt == '0);
            if (emit) begin
                bus.exp_out <= rd_exp;
                for (int unsigned i = 0; i < LANES; i++)
                    bus.dout[i] <= out_t'((rd_data[i] <<< rd_exp) >>> (DATA_WIDTH - OUT_WIDTH));
            end
        end
    end
`endif

endmodule

// File: tb/tb_cbfp_normalize.sv
// Directed bench for cbfp_normalize (default truncating build, 1-cycle latency).
module tb_cbfp_normalize;
    import cbfp_pkg::*;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    cbfp_normalize_if bus ();

    cbfp_normalize #(.BLK_BEATS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // streaming table: per block default din/mag, one special sample, expected exp/outputs
    int s_dd [3] = '{1000, -1000, 7};
    int s_dm [3] = '{12, 12, 19};
    int s_sb [3] = '{2, 1, 0};
    int s_sl [3] = '{9, 0, 3};
    int s_sd [3] = '{100000, 500, -4194304};
    int s_sm [3] = '{5, 13, 0};
    int s_e  [3] = '{5, 12, 0};
    int s_od [3] = '{7, -1000, 0};
    int s_os [3] = '{781, 500, -1024};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input int dd, input int dm, input int sl, input int sd, input int sm);
        bus.valid_in = v;
        for (int unsigned i = 0; i < LANES; i++) begin
            bus.din[i]    = sample_t'(dd);
            bus.mag_in[i] = mag_t'(dm);
        end
        if (sl >= 0) begin
            bus.din[sl]    = sample_t'(sd);
            bus.mag_in[sl] = mag_t'(sm);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".valid"}, bus.valid_out, 0);
        chk({tag, ".sop"},   bus.sop_out, 0);
        chk({tag, ".exp"},   bus.exp_out, 0);
        chk({tag, ".d0"},    bus.dout[0], 0);
        chk({tag, ".d15"},   bus.dout[15], 0);
    endtask

    task automatic check_beat(input string tag, input int b, input int sb, input int sl,
                              input int e, input int od, input int os);
        chk($sformatf("%s.b%0d.valid", tag, b), bus.valid_out, 1);
        chk($sformatf("%s.b%0d.sop", tag, b), bus.sop_out, (b == 0) ? 1 : 0);
        chk($sformatf("%s.b%0d.exp", tag, b), bus.exp_out, e);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s.b%0d.dout%0d", tag, b, i), bus.dout[i],
                (b == sb && i == sl) ? os : od);
    endtask

    task automatic run_block(input string tag, input bit gapped, input int dd, input int dm,
                             input int sb, input int sl, input int sd, input int sm,
                             input int e, input int od, input int os);
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, dd, dm, (b == sb) ? sl : -1, sd, sm);
            tick();
            chk($sformatf("%s.in%0d.novalid", tag, b), bus.valid_out, 0);
            if (gapped && b < 3) begin
                drive(1'b0, -4194304, 0, -1, 0, 0);
                tick();
                chk($sformatf("%s.gap%0d.novalid", tag, b), bus.valid_out, 0);
            end
        end
        drive(1'b0, 0, 0, -1, 0, 0);
        for (int b = 0; b < 4; b++) begin
            tick();
            check_beat(tag, b, sb, sl, e, od, os);
        end
        tick();
        chk({tag, ".after.valid"}, bus.valid_out, 0);
        chk({tag, ".after.exp_hold"}, bus.exp_out, e);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        drive(1'b0, 0, 0, -1, 0, 0);
        tick();
        tick();
        check_reset_outs("rst0");

        // partial block, then reset while still writing
        rstn = 1'b1;
        drive(1'b1, 100, 15, -1, 0, 0);
        tick();
        tick();
        chk("partial.novalid", bus.valid_out, 0);
        rstn = 1'b0;
        tick();
        drive(1'b0, 0, 0, -1, 0, 0);
        tick();
        check_reset_outs("rst1");
        rstn = 1'b1;

        run_block("pos",    1'b0, 1, 21, -1, -1, 0, 0, 21, 512, 0);
        run_block("negfs",  1'b0, 1, 21, 0, 5, -4194304, 0, 0, 0, -1024);
        run_block("allneg", 1'b0, -1, 22, -1, -1, 0, 0, 22, -1024, 0);
        run_block("clamp",  1'b0, -1, 31, -1, -1, 0, 0, 22, -1024, 0);

        for (int n = 0; n < 16; n++) begin
            if (n < 12) begin
                int k;
                int b;
                k = n / 4;
                b = n % 4;
                drive(1'b1, s_dd[k], s_dm[k], (b == s_sb[k]) ? s_sl[k] : -1, s_sd[k], s_sm[k]);
            end else begin
                drive(1'b0, 0, 0, -1, 0, 0);
            end
            tick();
            if (n < 4) begin
                chk($sformatf("stream.n%0d.novalid", n), bus.valid_out, 0);
            end else begin
                int k;
                k = (n - 4) / 4;
                check_beat($sformatf("stream%0d", k), (n - 4) % 4, s_sb[k], s_sl[k],
                           s_e[k], s_od[k], s_os[k]);
            end
        end
        tick();
        chk("stream.end.novalid", bus.valid_out, 0);

        run_block("gap",  1'b1, 3, 20, 1, 7, 12, 18, 18, 192, 768);
        run_block("post", 1'b0, 1000, 12, 2, 9, 100000, 5, 5, 7, 781);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
